// File: rtl/encoder_rr_pkg.sv
// Shared constants and helpers for the encoder_rr priority encoder and
// other parametrised library blocks.
package encoder_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Number of bits needed to hold the values 0 .. n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/encoder_rr_if.sv
// Request/result handshake bundle for encoder_rr; the slave modport is the
// encoder side, the master modport is the producer/consumer side.
interface encoder_rr_if
    import encoder_rr_pkg::*;
#(
    parameter int N = 16
);
    localparam int W = clog2(N);

    logic         I_MODE;
    logic [N-1:0] I_DATA;
    logic         I_VALID;
    logic         O_READY;
    logic [W-1:0] O_DATA;
    logic [N-1:0] O_GRANT;
    logic         O_ZERO;
    logic         O_MULTI;
    logic         O_VALID;
    logic         I_READY;

    modport slave (
        input  I_MODE, I_DATA, I_VALID, I_READY,
        output O_READY, O_DATA, O_GRANT, O_ZERO, O_MULTI, O_VALID
    );

    modport master (
        output I_MODE, I_DATA, I_VALID, I_READY,
        input  O_READY, O_DATA, O_GRANT, O_ZERO, O_MULTI, O_VALID
    );

endinterface

// File: rtl/encoder_rr_select.sv
// Combinational masked priority pick: the first set request at or after ptr,
// wrapping modulo N, found by rotating a doubled copy of the request vector.
module encoder_rr_select
    import encoder_rr_pkg::*;
#(
    parameter int N = 16,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic [N-1:0] grant,
    output logic         zero,
    output logic         multi
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           found;
    int             pos;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        found = 1'b0;
        pos   = 0;
        idx   = '0;
        // rot[k] stands for request index (ptr + k) mod N
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = int'(ptr) + k;
                if (pos >= N) begin
                    pos = pos - N;
                end
                idx = W'(pos);
            end
        end
        grant = found ? (N'(1) << idx) : '0;
        zero  = ~|req;
        multi = |(req & (req - N'(1)));
    end

endmodule

// File: rtl/encoder_rr.sv
// N-to-log2(N) priority encoder with fixed or round-robin priority, a
// registered result and valid/ready handshakes on both sides.
module encoder_rr
    import encoder_rr_pkg::*;
#(
    parameter int N = 16
) (
    input  logic       I_CLK,
    input  logic       I_NRESET,
    encoder_rr_if.slave bus
);

    localparam int W = clog2(N);

    logic [W-1:0] ptr;
    logic [W-1:0] sel_ptr;
    logic [W-1:0] sel_idx;
    logic [N-1:0] sel_grant;
    logic         sel_zero;
    logic         sel_multi;
    logic         ready;
    logic         acc;

    logic [W-1:0] data_p1;
    logic [N-1:0] grant_p1;
    logic         zero_p1;
    logic         multi_p1;
    logic         vld_p1;

    assign ready   = !vld_p1 || bus.I_READY;
    assign acc     = bus.I_VALID && ready;
    assign sel_ptr = (bus.I_MODE == MODE_RR) ? ptr : '0;

    encoder_rr_select #(.N(N), .W(W)) u_select (
        .req   (bus.I_DATA),
        .ptr   (sel_ptr),
        .idx   (sel_idx),
        .grant (sel_grant),
        .zero  (sel_zero),
        .multi (sel_multi)
    );

    // Stage p0 -> p1: register the pick on accept; pointer moves past the winner
    always_ff @(posedge I_CLK) begin
        if (!I_NRESET) begin
            ptr      <= '0;
            data_p1  <= '0;
            grant_p1 <= '0;
            zero_p1  <= 1'b0;
            multi_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else if (acc) begin
            data_p1  <= sel_idx;
            grant_p1 <= sel_grant;
            zero_p1  <= sel_zero;
            multi_p1 <= sel_multi;
            vld_p1   <= 1'b1;
            if (bus.I_MODE == MODE_RR && !sel_zero) begin
                ptr <= (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
            end
        end else if (bus.I_READY) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.O_READY = ready;
    assign bus.O_DATA  = data_p1;
    assign bus.O_GRANT = grant_p1;
    assign bus.O_ZERO  = zero_p1;
    assign bus.O_MULTI = multi_p1;
    assign bus.O_VALID = vld_p1;

endmodule

// File: tb/tb_encoder_rr.sv
// Directed bench for encoder_rr: a 16-request instance for the main sequence
// and a 5-request instance for round-robin wrap at a non-power-of-two width.
module tb_encoder_rr;

    logic clk;
    logic nrst;
    int   vectors;
    int   errs;

    encoder_rr_if #(.N(16)) bus ();
    encoder_rr_if #(.N(5))  bus5 ();

    encoder_rr #(.N(16)) dut (
        .I_CLK    (clk),
        .I_NRESET (nrst),
        .bus      (bus.slave)
    );

    encoder_rr #(.N(5)) dut5 (
        .I_CLK    (clk),
        .I_NRESET (nrst),
        .bus      (bus5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0;
        errs    = 0;

        // 1. reset held two edges with a full request vector offered
        nrst          = 1'b0;
        bus.I_MODE    = 1'b0;
        bus.I_DATA    = 16'hFFFF;
        bus.I_VALID   = 1'b1;
        bus.I_READY   = 1'b1;
        bus5.I_MODE   = 1'b1;
        bus5.I_DATA   = 5'b0;
        bus5.I_VALID  = 1'b0;
        bus5.I_READY  = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(bus.O_VALID), 32'd0);
        chk("rst_data",  32'(bus.O_DATA),  32'd0);
        chk("rst_grant", 32'(bus.O_GRANT), 32'd0);
        chk("rst_zero",  32'(bus.O_ZERO),  32'd0);
        chk("rst_multi", 32'(bus.O_MULTI), 32'd0);
        chk("rst_ready", 32'(bus.O_READY), 32'd1);

        // 2. fixed priority, lowest set bit of 0x0090 is bit 4
        nrst       = 1'b1;
        bus.I_MODE = 1'b0;
        bus.I_DATA = 16'h0090;
        tick();
        chk("fix_valid", 32'(bus.O_VALID), 32'd1);
        chk("fix_data",  32'(bus.O_DATA),  32'd4);
        chk("fix_grant", 32'(bus.O_GRANT), 32'h0010);
        chk("fix_multi", 32'(bus.O_MULTI), 32'd1);
        chk("fix_zero",  32'(bus.O_ZERO),  32'd0);
        chk("fix_ptr",   32'(dut.ptr),     32'd0);

        // 3. round-robin wrap on 0x8001 (and 5'b10001 on the N=5 instance)
        nrst = 1'b0;
        tick();
        nrst         = 1'b1;
        bus.I_MODE   = 1'b1;
        bus.I_DATA   = 16'h8001;
        bus5.I_DATA  = 5'b10001;
        bus5.I_VALID = 1'b1;
        tick();
        chk("rr1_data",   32'(bus.O_DATA),   32'd0);
        chk("rr1_grant",  32'(bus.O_GRANT),  32'h0001);
        chk("rr1_ptr",    32'(dut.ptr),      32'd1);
        chk("rr5_1_data", 32'(bus5.O_DATA),  32'd0);
        chk("rr5_1_ptr",  32'(dut5.ptr),     32'd1);
        tick();
        chk("rr2_data",   32'(bus.O_DATA),   32'd15);
        chk("rr2_grant",  32'(bus.O_GRANT),  32'h8000);
        chk("rr2_valid",  32'(bus.O_VALID),  32'd1);
        chk("rr2_ptr",    32'(dut.ptr),      32'd0);
        chk("rr5_2_data", 32'(bus5.O_DATA),  32'd4);
        chk("rr5_2_grnt", 32'(bus5.O_GRANT), 32'h10);
        chk("rr5_2_ptr",  32'(dut5.ptr),     32'd0);
        tick();
        chk("rr3_data",   32'(bus.O_DATA),   32'd0);
        chk("rr3_ptr",    32'(dut.ptr),      32'd1);
        chk("rr5_3_data", 32'(bus5.O_DATA),  32'd0);
        chk("rr5_3_ptr",  32'(dut5.ptr),     32'd1);
        bus5.I_VALID = 1'b0;

        // 4. move pointer to 5, then a zero vector leaves it there
        bus.I_DATA = 16'h0010;
        tick();
        chk("z_pre_data", 32'(bus.O_DATA),  32'd4);
        chk("z_pre_ptr",  32'(dut.ptr),     32'd5);
        chk("z_pre_mul",  32'(bus.O_MULTI), 32'd0);
        bus.I_DATA = 16'h0000;
        tick();
        chk("zero_zero",  32'(bus.O_ZERO),  32'd1);
        chk("zero_data",  32'(bus.O_DATA),  32'd0);
        chk("zero_grant", 32'(bus.O_GRANT), 32'd0);
        chk("zero_multi", 32'(bus.O_MULTI), 32'd0);
        chk("zero_ptr",   32'(dut.ptr),     32'd5);
        bus.I_DATA = 16'h0021;
        tick();
        chk("z_post_data", 32'(bus.O_DATA), 32'd5);
        chk("z_post_zero", 32'(bus.O_ZERO), 32'd0);
        chk("z_post_ptr",  32'(dut.ptr),    32'd6);

        // 5. backpressure: result 3 held while the input vector churns
        bus.I_MODE = 1'b0;
        bus.I_DATA = 16'h0008;
        tick();
        chk("bp_load", 32'(bus.O_DATA), 32'd3);
        bus.I_READY = 1'b0;
        #1;
        chk("bp_ready0", 32'(bus.O_READY), 32'd0);
        for (int i = 0; i < 5; i++) begin
            bus.I_DATA = 16'h0001 << i;
            bus.I_MODE = i[0];
            tick();
            chk("bp_hold_data",  32'(bus.O_DATA),  32'd3);
            chk("bp_hold_grant", 32'(bus.O_GRANT), 32'h0008);
            chk("bp_hold_valid", 32'(bus.O_VALID), 32'd1);
            chk("bp_hold_ready", 32'(bus.O_READY), 32'd0);
        end
        bus.I_MODE  = 1'b0;
        bus.I_DATA  = 16'h0040;
        bus.I_READY = 1'b1;
        #1;
        chk("bp_ready1", 32'(bus.O_READY), 32'd1);
        tick();
        chk("bp_new_data",  32'(bus.O_DATA),  32'd6);
        chk("bp_new_valid", 32'(bus.O_VALID), 32'd1);
        bus.I_VALID = 1'b0;
        bus.I_DATA  = 'x;
        tick();
        chk("drain_valid", 32'(bus.O_VALID), 32'd0);
        chk("drain_ptr",   32'(dut.ptr),     32'd6);

        // 6. reset while a result is stalled, pointer at 9
        bus.I_MODE  = 1'b1;
        bus.I_DATA  = 16'h0100;
        bus.I_VALID = 1'b1;
        tick();
        chk("mr_pre_data", 32'(bus.O_DATA), 32'd8);
        chk("mr_pre_ptr",  32'(dut.ptr),    32'd9);
        bus.I_READY = 1'b0;
        bus.I_VALID = 1'b0;
        tick();
        chk("mr_stall_valid", 32'(bus.O_VALID), 32'd1);
        nrst        = 1'b0;
        bus.I_VALID = 1'b1;
        bus.I_DATA  = 16'hFFFF;
        tick();
        chk("mr_valid", 32'(bus.O_VALID), 32'd0);
        chk("mr_ptr",   32'(dut.ptr),     32'd0);
        chk("mr_data",  32'(bus.O_DATA),  32'd0);
        nrst        = 1'b1;
        bus.I_DATA  = 16'h0300;
        bus.I_READY = 1'b1;
        tick();
        chk("mr_post_data",  32'(bus.O_DATA),  32'd8);
        chk("mr_post_grant", 32'(bus.O_GRANT), 32'h0100);
        chk("mr_post_multi", 32'(bus.O_MULTI), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
